crypto_xperm_pipe: RTL and testbench
====================================

CRYPTO_XPERM_PIPE -- requirements
Module: crypto_xperm_pipe

Interface
REQ-001 SHALL have parameter TRANS_ID_BITS, default 3, meaning the width of the transaction tag carried with each operation.
REQ-002 SHALL take XLEN (32 or 64) from crypto_instr_pkg; it is not a module parameter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i, input, 1 bit: kill all in-flight operations.
REQ-006 SHALL have port valid_i, input, 1 bit: issue request.
REQ-007 SHALL have port ready_o, output, 1 bit: pipe can accept this cycle.
REQ-008 SHALL have port op_i, input, crypto_xperm_op_t: XPERM_OP_4, XPERM_OP_8 or XPERM_OP_NONE.
REQ-009 SHALL have ports rs1_i and rs2_i, input, XLEN bits each: lookup table (rs1) and index vector (rs2).
REQ-010 SHALL have port trans_id_i, input, TRANS_ID_BITS: tag of the issued operation.
REQ-011 SHALL have port valid_o, output, 1 bit: result available.
REQ-012 SHALL have port ready_i, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port result_o, output, XLEN bits: permutation result.
REQ-014 SHALL have port trans_id_o, output, TRANS_ID_BITS: tag of the result.
REQ-015 SHALL have port illegal_o, output, 1 bit: op was XPERM_OP_NONE; qualified by valid_o.
REQ-016 SHALL have port busy_o, output, 1 bit: any stage holds a valid entry.

Function
REQ-017 SHALL be a two-stage pipe.
- S1 registers op, rs1, rs2 and tag when valid_i && ready_o.
- S2 registers the computed result, tag and illegal flag.
REQ-018 SHALL have latency 2: an operation accepted at edge N drives valid_o after edge N+1, with no backpressure.
REQ-019 SHALL compute XPERM8 as result byte k = rs1 byte rs2[8k+7:8k] when the index is < XLEN/8, else 0x00.
REQ-020 SHALL compute XPERM4 as result nibble k = rs1 nibble rs2[4k+3:4k] when the index is < XLEN/4, else 0x0.
- For XLEN=64 the nibble index is always in range.
REQ-021 SHALL, for op XPERM_OP_NONE, set result_o to 0 and illegal_o to 1.
REQ-022 SHALL drive ready_o = !flush_i && (!s1_valid || !s2_valid || ready_i).
- Sustains one operation per cycle under no backpressure.
REQ-023 SHALL advance S1 into S2 when s1_valid && (!s2_valid || ready_i).
REQ-024 SHALL clear s1_valid when S1 advances and no new issue occurs in the same cycle.
REQ-025 SHALL hold result_o, trans_id_o and illegal_o stable while valid_o && !ready_i.
REQ-026 SHALL, on a simultaneous issue and S1 advance, load S1 with the new op and S2 with the old op in the same cycle.
REQ-027 SHALL, with flush_i high, clear s1_valid and s2_valid at the next edge and ignore valid_i.
- Flush overrides issue and advance.
- Datapath registers need not clear.
REQ-028 SHALL drive busy_o = s1_valid || s2_valid.
REQ-029 SHALL never drop or duplicate an accepted, unflushed operation; results leave in issue order.

Reset
REQ-030 SHALL, on rst_ni low (asynchronous), clear s1_valid and s2_valid.
REQ-031 SHALL, on reset, clear result_o, trans_id_o and illegal_o to 0.
REQ-032 SHALL give valid_o=0, busy_o=0 and ready_o=1 while in reset and in the first cycle after release.
REQ-033 SHALL discard any in-flight operation on reset mid-operation; no result for it is ever produced.

Structure
REQ-034 SHALL place crypto_xperm_op_t (2-bit enum) in crypto_instr_pkg; XLEN is also defined there.
REQ-035 SHALL use one combinational sub-module, crypto_xperm_core, between S1 and S2 (op, rs1, rs2 -> result).
- No other sub-modules.

Verification (XLEN=64)
REQ-036 SHALL check XPERM8 with rs1=0x8877665544332211, rs2=0x0000000000000007, tag 3.
- Required: result 0x1111111111111188, tag 3, exactly 2 cycles after accept.
REQ-037 SHALL check XPERM8 out-of-range index with rs1 as above, rs2=0x0000000000000008.
- Required: result 0x1111111111111100.
REQ-038 SHALL check XPERM4 with rs1=0xFEDCBA9876543210, rs2=0x0123456789ABCDEF.
- Required: result 0x0123456789ABCDEF.
REQ-039 SHALL check backpressure with 4 back-to-back issues, tags 0..3, and ready_i low for 3 cycles.
- Required: ready_o drops once both stages are full.
- Required: result_o held stable while stalled.
- Required: tags emerge 0,1,2,3 with none lost.
REQ-040 SHALL check flush with both stages full and flush_i for 1 cycle.
- Required: valid_o=0 and busy_o=0 next cycle.
- Required: an issue attempted during the flush cycle is not accepted.
REQ-041 SHALL check reset asserted mid-stream.
- Required: valid_o falls asynchronously and no stale result follows; op XPERM_OP_NONE then yields illegal_o=1 and result 0.

Source files
------------

// File: rtl/crypto_instr_pkg.sv
// Shared types and widths for the crypto permutation instructions.
// XLEN selects the RV32 (32) or RV64 (64) datapath width.
package crypto_instr_pkg;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned NBYTE = XLEN / 8;
   localparam int unsigned NNIB  = XLEN / 4;

   typedef enum logic [1:0] {
      XPERM_OP_NONE = 2'd0,
      XPERM_OP_4    = 2'd1,
      XPERM_OP_8    = 2'd2
   } crypto_xperm_op_t;

endpackage

// File: rtl/crypto_xperm_core.sv
// Combinational xperm4/xperm8 lookup: rs1 is the table, rs2 the indices.
// Out-of-range indices select zero; an unknown op flags illegal.
module crypto_xperm_core
   import crypto_instr_pkg::*;
(
   input  crypto_xperm_op_t op_i,
   input  logic [XLEN-1:0]  rs1_i,
   input  logic [XLEN-1:0]  rs2_i,
   output logic [XLEN-1:0]  result_o,
   output logic             illegal_o
);

   logic [XLEN-1:0] perm8;
   logic [XLEN-1:0] perm4;

   // An index matching no table entry leaves its lane at zero.
   always_comb begin
      perm8 = '0;
      for (int k = 0; k < NBYTE; k++) begin
         for (int j = 0; j < NBYTE; j++) begin
            if (rs2_i[8*k +: 8] == 8'(j)) begin
               perm8[8*k +: 8] = rs1_i[8*j +: 8];
            end
         end
      end
   end

   always_comb begin
      perm4 = '0;
      for (int k = 0; k < NNIB; k++) begin
         for (int j = 0; j < NNIB; j++) begin
            if (rs2_i[4*k +: 4] == 4'(j)) begin
               perm4[4*k +: 4] = rs1_i[4*j +: 4];
            end
         end
      end
   end

   always_comb begin
      result_o  = '0;
      illegal_o = 1'b0;
      unique case (op_i)
         XPERM_OP_8: result_o = perm8;
         XPERM_OP_4: result_o = perm4;
         default:    illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/crypto_xperm_pipe.sv
// Two-stage xperm pipe: S1 holds operands, S2 holds the result.
// Valid/ready on both sides; flush kills everything in flight.
module crypto_xperm_pipe
   import crypto_instr_pkg::*;
#(
   parameter int unsigned TRANS_ID_BITS = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  crypto_xperm_op_t         op_i,
   input  logic [XLEN-1:0]          rs1_i,
   input  logic [XLEN-1:0]          rs2_i,
   input  logic [TRANS_ID_BITS-1:0] trans_id_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [XLEN-1:0]          result_o,
   output logic [TRANS_ID_BITS-1:0] trans_id_o,
   output logic                     illegal_o,
   output logic                     busy_o
);

   logic                     s1_valid_q, s1_valid_d;
   crypto_xperm_op_t         s1_op_q,    s1_op_d;
   logic [XLEN-1:0]          s1_rs1_q,   s1_rs1_d;
   logic [XLEN-1:0]          s1_rs2_q,   s1_rs2_d;
   logic [TRANS_ID_BITS-1:0] s1_tid_q,   s1_tid_d;

   logic                     s2_valid_q, s2_valid_d;
   logic [XLEN-1:0]          s2_res_q,   s2_res_d;
   logic [TRANS_ID_BITS-1:0] s2_tid_q,   s2_tid_d;
   logic                     s2_ill_q,   s2_ill_d;

   logic            issue;
   logic            advance;
   logic [XLEN-1:0] core_res;
   logic            core_ill;

   assign ready_o = !flush_i && (!s1_valid_q || !s2_valid_q || ready_i);
   assign issue   = valid_i && ready_o;
   assign advance = s1_valid_q && (!s2_valid_q || ready_i);

   crypto_xperm_core u_core (
      .op_i      (s1_op_q),
      .rs1_i     (s1_rs1_q),
      .rs2_i     (s1_rs2_q),
      .result_o  (core_res),
      .illegal_o (core_ill)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_rs1_d   = s1_rs1_q;
      s1_rs2_d   = s1_rs2_q;
      s1_tid_d   = s1_tid_q;
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_tid_d   = s2_tid_q;
      s2_ill_d   = s2_ill_q;

      if (issue) begin
         s1_op_d  = op_i;
         s1_rs1_d = rs1_i;
         s1_rs2_d = rs2_i;
         s1_tid_d = trans_id_i;
      end

      // S2 data only moves when S2 is empty or being drained.
      if (advance) begin
         s2_res_d = core_res;
         s2_tid_d = s1_tid_q;
         s2_ill_d = core_ill;
      end

      if (flush_i) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (issue) begin
            s1_valid_d = 1'b1;
         end else if (advance) begin
            s1_valid_d = 1'b0;
         end
         if (advance) begin
            s2_valid_d = 1'b1;
         end else if (ready_i) begin
            s2_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= XPERM_OP_NONE;
         s1_rs1_q   <= '0;
         s1_rs2_q   <= '0;
         s1_tid_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_tid_q   <= '0;
         s2_ill_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_rs1_q   <= s1_rs1_d;
         s1_rs2_q   <= s1_rs2_d;
         s1_tid_q   <= s1_tid_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_tid_q   <= s2_tid_d;
         s2_ill_q   <= s2_ill_d;
      end
   end

   assign valid_o    = s2_valid_q;
   assign result_o   = s2_res_q;
   assign trans_id_o = s2_tid_q;
   assign illegal_o  = s2_ill_q;
   assign busy_o     = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_crypto_xperm_pipe.sv
// Bench for crypto_xperm_pipe: vector table plus directed stall,
// flush and reset sequences, all results checked by a scoreboard.
module tb_crypto_xperm_pipe;
   import crypto_instr_pkg::*;

   localparam int TB = 3;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             flush_i = 1'b0;
   logic             valid_i = 1'b0;
   logic             ready_i = 1'b1;
   crypto_xperm_op_t op_i = XPERM_OP_NONE;
   logic [XLEN-1:0]  rs1_i = '0;
   logic [XLEN-1:0]  rs2_i = '0;
   logic [TB-1:0]    trans_id_i = '0;
   logic             ready_o;
   logic             valid_o;
   logic [XLEN-1:0]  result_o;
   logic [TB-1:0]    trans_id_o;
   logic             illegal_o;
   logic             busy_o;

   crypto_xperm_pipe #(.TRANS_ID_BITS(TB)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .op_i       (op_i),
      .rs1_i      (rs1_i),
      .rs2_i      (rs2_i),
      .trans_id_i (trans_id_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .result_o   (result_o),
      .trans_id_o (trans_id_o),
      .illegal_o  (illegal_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      crypto_xperm_op_t op;
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      logic [XLEN-1:0]  res;
      logic             ill;
   } vec_t;

   typedef struct {
      logic [XLEN-1:0] res;
      logic [TB-1:0]   tid;
      logic            ill;
   } sb_t;

   vec_t            tv[10];
   sb_t             q[$];
   logic [XLEN-1:0] exp_res_drv = '0;
   logic            exp_ill_drv = 1'b0;
   int              n_cmp = 0;
   int              n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   function automatic logic [XLEN:0] model(input crypto_xperm_op_t op,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      logic [XLEN-1:0] t;
      int idx;
      r = '0;
      case (op)
         XPERM_OP_8: begin
            for (int k = 0; k < XLEN / 8; k++) begin
               t = b >> (8 * k);
               idx = int'(t[7:0]);
               if (idx < XLEN / 8) begin
                  t = a >> (8 * idx);
                  r = r | (XLEN'(t[7:0]) << (8 * k));
               end
            end
         end
         XPERM_OP_4: begin
            for (int k = 0; k < XLEN / 4; k++) begin
               t = b >> (4 * k);
               idx = int'(t[3:0]);
               if (idx < XLEN / 4) begin
                  t = a >> (4 * idx);
                  r = r | (XLEN'(t[3:0]) << (4 * k));
               end
            end
         end
         default: return {1'b1, {XLEN{1'b0}}};
      endcase
      return {1'b0, r};
   endfunction

   // Scoreboard: decide at the falling edge what the next rising edge does.
   always @(negedge clk_i) begin
      sb_t e;
      if (rst_ni) begin
         if (valid_o && ready_i) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb_unexpected: got tag %0d result %h, required no output",
                        trans_id_o, result_o);
            end else begin
               e = q.pop_front();
               chk("sb_result", 64'(result_o), 64'(e.res));
               chk("sb_tag", 64'(trans_id_o), 64'(e.tid));
               chk("sb_illegal", 64'(illegal_o), 64'(e.ill));
            end
         end
         if (flush_i) q.delete();
         if (valid_i && ready_o) q.push_back('{exp_res_drv, trans_id_i, exp_ill_drv});
      end
   end

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_op(input crypto_xperm_op_t op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TB-1:0] tid);
      logic [XLEN:0] m;
      m = model(op, a, b);
      op_i        = op;
      rs1_i       = a;
      rs2_i       = b;
      trans_id_i  = tid;
      exp_res_drv = m[XLEN-1:0];
      exp_ill_drv = m[XLEN];
      valid_i     = 1'b1;
   endtask

   task automatic set_rand(input logic [TB-1:0] tid);
      crypto_xperm_op_t op;
      op = ($urandom_range(0, 1) == 0) ? XPERM_OP_4 : XPERM_OP_8;
      set_op(op, {$urandom, $urandom}, {$urandom, $urandom} & 64'h0F0F0F0F0F0F0F0F, tid);
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      while ((busy_o || valid_o) && n < 20) begin
         tick;
         n++;
      end
      chk({nm, "_drain_busy"}, 64'(busy_o), 64'd0);
      chk({nm, "_sb_empty"}, 64'(q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [XLEN-1:0] held;
      logic            acc;
      int              n;

      tv[0] = '{XPERM_OP_8, 64'h8877665544332211, 64'h0000000000000007, 64'h1111111111111188, 1'b0};
      tv[1] = '{XPERM_OP_8, 64'h8877665544332211, 64'h0000000000000008, 64'h1111111111111100, 1'b0};
      tv[2] = '{XPERM_OP_4, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0};
      tv[3] = '{XPERM_OP_8, 64'h8877665544332211, 64'h0706050403020100, 64'h8877665544332211, 1'b0};
      tv[4] = '{XPERM_OP_8, 64'h8877665544332211, 64'h0001020304050607, 64'h1122334455667788, 1'b0};
      tv[5] = '{XPERM_OP_8, 64'h8877665544332211, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 1'b0};
      tv[6] = '{XPERM_OP_4, 64'hFEDCBA9876543210, 64'h0000000000000000, 64'h0000000000000000, 1'b0};
      tv[7] = '{XPERM_OP_4, 64'h0123456789ABCDEF, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b0};
      tv[8] = '{XPERM_OP_NONE, 64'h0123456789ABCDEF, 64'h1111111111111111, 64'h0000000000000000, 1'b1};
      tv[9] = '{XPERM_OP_8, 64'h8877665544332211, 64'h8000000000000001, 64'h0011111111111122, 1'b0};

      // Reset state and first cycle after release.
      repeat (3) tick;
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_result", 64'(result_o), 64'd0);
      rst_ni = 1'b1;
      chk("rel_valid", 64'(valid_o), 64'd0);
      chk("rel_ready", 64'(ready_o), 64'd1);
      tick;

      // Table vectors, back to back, no backpressure.
      for (int i = 0; i < 10; i++) begin
         op_i        = tv[i].op;
         rs1_i       = tv[i].a;
         rs2_i       = tv[i].b;
         trans_id_i  = TB'(i);
         exp_res_drv = tv[i].res;
         exp_ill_drv = tv[i].ill;
         valid_i     = 1'b1;
         chk($sformatf("tv%0d_ready", i), 64'(ready_o), 64'd1);
         tick;
      end
      drain("tv");

      // Latency: accepted at edge N, valid after edge N+1.
      set_op(XPERM_OP_8, 64'h8877665544332211, 64'h0000000000000007, 3'd3);
      tick;
      valid_i = 1'b0;
      chk("lat_n_valid", 64'(valid_o), 64'd0);
      tick;
      chk("lat_n1_valid", 64'(valid_o), 64'd1);
      chk("lat_result", 64'(result_o), 64'h1111111111111188);
      chk("lat_tag", 64'(trans_id_o), 64'd3);
      drain("lat");

      // Backpressure: fill both stages and stall for three cycles.
      ready_i = 1'b0;
      set_rand(3'd0);
      chk("bp_ready_t0", 64'(ready_o), 64'd1);
      tick;
      set_rand(3'd1);
      chk("bp_ready_t1", 64'(ready_o), 64'd1);
      tick;
      set_rand(3'd2);
      chk("bp_ready_drop", 64'(ready_o), 64'd0);
      chk("bp_valid", 64'(valid_o), 64'd1);
      held = result_o;
      for (int c = 0; c < 3; c++) begin
         tick;
         chk($sformatf("bp_hold_res%0d", c), 64'(result_o), 64'(held));
         chk($sformatf("bp_hold_tag%0d", c), 64'(trans_id_o), 64'd0);
         chk($sformatf("bp_hold_rdy%0d", c), 64'(ready_o), 64'd0);
      end
      ready_i = 1'b1;
      for (int t = 2; t < 4; t++) begin
         if (t == 3) set_rand(3'd3);
         n = 0;
         do begin
            acc = ready_o;
            tick;
            n++;
         end while (!acc && n < 10);
         chk($sformatf("bp_accept_t%0d", t), 64'(acc), 64'd1);
      end
      drain("bp");

      // Flush with both stages full; a simultaneous issue is refused.
      ready_i = 1'b0;
      set_rand(3'd5);
      tick;
      set_rand(3'd6);
      tick;
      chk("fl_pre_busy", 64'(busy_o), 64'd1);
      chk("fl_pre_valid", 64'(valid_o), 64'd1);
      set_rand(3'd7);
      flush_i = 1'b1;
      chk("fl_ready", 64'(ready_o), 64'd0);
      tick;
      flush_i = 1'b0;
      valid_i = 1'b0;
      chk("fl_valid", 64'(valid_o), 64'd0);
      chk("fl_busy", 64'(busy_o), 64'd0);
      ready_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick;
         chk($sformatf("fl_quiet%0d", c), 64'(valid_o), 64'd0);
      end
      chk("fl_sb_empty", 64'(q.size()), 64'd0);

      // Reset asserted mid-stream, between clock edges.
      ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_rand(TB'(i));
         tick;
      end
      chk("rs_pre_valid", 64'(valid_o), 64'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("rs_async_valid", 64'(valid_o), 64'd0);
      chk("rs_async_busy", 64'(busy_o), 64'd0);
      chk("rs_async_ready", 64'(ready_o), 64'd1);
      chk("rs_async_res", 64'(result_o), 64'd0);
      chk("rs_async_tag", 64'(trans_id_o), 64'd0);
      chk("rs_async_ill", 64'(illegal_o), 64'd0);
      q.delete();
      valid_i = 1'b0;
      tick;
      tick;
      rst_ni = 1'b1;
      chk("rs_rel_valid", 64'(valid_o), 64'd0);
      chk("rs_rel_busy", 64'(busy_o), 64'd0);
      chk("rs_rel_ready", 64'(ready_o), 64'd1);
      for (int c = 0; c < 3; c++) begin
         tick;
         chk($sformatf("rs_no_stale%0d", c), 64'(valid_o), 64'd0);
      end
      set_op(XPERM_OP_NONE, {$urandom, $urandom}, {$urandom, $urandom}, 3'd4);
      tick;
      valid_i = 1'b0;
      tick;
      chk("none_valid", 64'(valid_o), 64'd1);
      chk("none_illegal", 64'(illegal_o), 64'd1);
      chk("none_result", 64'(result_o), 64'd0);
      chk("none_tag", 64'(trans_id_o), 64'd4);
      drain("none");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
